// File: rtl/fibo_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fibo_seq_ctrl
// Description : Request/response sequencer for a Fibonacci datapath made of
//               two WIDTH-bit registers (Fn1/Fn2) and a WIDTH-bit adder.
//               A request carries an index n. The controller clears the
//               datapath and issues exactly n-2 step pulses. It then captures
//               F(n) truncated to WIDTH bits, together with a sticky
//               carry-out (overflow) flag. One job is in flight at a time.
// Ports       : clk, reset     - clock (rising edge), async active-low reset
//               req_valid/req_ready/req_n - request handshake and index
//               dp_clr/dp_step  - datapath load and advance commands
//               dp_fn           - datapath sum Fn1+Fn2, carry-out in MSB
//               rsp_valid/rsp_ready/rsp_fib/rsp_ovf - response handshake
//               busy            - a job is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fibo_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int NW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NW-1:0]    req_n,
  output logic             dp_clr,
  output logic             dp_step,
  input  logic [WIDTH:0]   dp_fn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_fib,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_EVAL  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fib_q, fib_d;
  logic             ovf_q, ovf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fib_q       <= '0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fib_q       <= fib_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fib_d   = fib_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ovf_d = 1'b0;
          if (req_n < NW'(2)) begin
            // F(0)=0 and F(1)=1 need no datapath activity.
            fib_d   = WIDTH'(req_n[0]);
            state_d = S_RESP;
          end else begin
            // After the clear, the sum already holds F(2); n-2 steps remain.
            cnt_d   = req_n - NW'(2);
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        // Any carry-out seen during the job makes the result inexact.
        if (dp_fn[WIDTH]) begin
          ovf_d = 1'b1;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - NW'(1);
        end else begin
          fib_d   = dp_fn[WIDTH-1:0];
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered flags track the state being entered, so they line up with state_q.
  assign rsp_valid_d = (state_d == S_RESP);
  assign busy_d      = (state_d != S_IDLE);

  // Decoded from registered state/counter only; CLEAR and EVAL are exclusive,
  // so clear and step can never coincide.
  assign req_ready = (state_q == S_IDLE);
  assign dp_clr    = (state_q == S_CLEAR);
  assign dp_step   = (state_q == S_EVAL) && (cnt_q != '0);

  assign rsp_valid = rsp_valid_q;
  assign rsp_fib   = fib_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fibo_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibo_seq_ctrl
// Description : Bench for fibo_seq_ctrl with a behavioural Fibonacci datapath.
//               Expected responses come from an independent arithmetic model.
//               They are queued when a request is driven and compared when
//               rsp_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibo_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int NW    = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [NW-1:0]    req_n = '0;
  logic             dp_clr;
  logic             dp_step;
  logic [WIDTH:0]   dp_fn;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_fib;
  logic             rsp_ovf;
  logic             busy;

  fibo_seq_ctrl #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .dp_clr    (dp_clr),
    .dp_step   (dp_step),
    .dp_fn     (dp_fn),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_fib   (rsp_fib),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: Fn1/Fn2 registers and the ripple-adder sum.
  logic [WIDTH-1:0] fn1_q, fn2_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fn1_q <= '0;
      fn2_q <= '0;
    end else if (dp_clr) begin
      fn1_q <= WIDTH'(1);
      fn2_q <= '0;
    end else if (dp_step) begin
      fn1_q <= dp_fn[WIDTH-1:0];
      fn2_q <= fn1_q;
    end
  end
  assign dp_fn = {1'b0, fn1_q} + {1'b0, fn2_q};

  typedef struct {
    int fib;
    int ovf;
    int lat;
    int steps;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: truncated Fibonacci arithmetic with sticky carry tracking.
  function automatic exp_t model(input int n);
    exp_t        e;
    int unsigned a, b, s;
    e.ovf = 0;
    if (n < 2) begin
      e.fib   = n;
      e.lat   = 1;
      e.steps = 0;
      return e;
    end
    a = 1;
    b = 0;
    s = 0;
    for (int k = 0; k <= n - 2; k++) begin
      s = a + b;
      if (s >= (1 << WIDTH)) e.ovf = 1;
      s = s % (1 << WIDTH);
      b = a;
      a = s;
    end
    e.fib   = int'(s);
    e.lat   = n + 1;
    e.steps = n - 2;
    return e;
  endfunction

  // Called #1 after a rising edge with the bench in an idle cycle.
  task automatic run_job(input int n, input int hold);
    exp_t             e;
    int               cyc, clr_cnt, step_cnt, both_cnt;
    logic [WIDTH-1:0] fib_hold;
    logic             ovf_hold;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_n     = NW'(n);
    sb_q.push_back(model(n));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_n     = NW'($urandom);  // must be ignored while busy
    cyc       = 1;
    clr_cnt   = 0;
    step_cnt  = 0;
    both_cnt  = 0;
    chk("dp_clr_at_T1", dp_clr, (n >= 2) ? 1 : 0);
    while (!rsp_valid && cyc < 200) begin
      if (dp_clr) clr_cnt++;
      if (dp_step) step_cnt++;
      if (dp_clr && dp_step) both_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    chk("latency", cyc, e.lat);
    chk("rsp_fib", rsp_fib, e.fib);
    chk("rsp_ovf", rsp_ovf, e.ovf);
    chk("step_count", step_cnt, e.steps);
    chk("clr_count", clr_cnt, (n >= 2) ? 1 : 0);
    chk("clr_step_overlap", both_cnt, 0);
    chk("busy_resp", busy, 1);
    fib_hold = rsp_fib;
    ovf_hold = rsp_ovf;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_n     = NW'(3);
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_fib", rsp_fib, fib_hold);
      chk("hold_ovf", rsp_ovf, ovf_hold);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    int stray;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_fib", rsp_fib, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    chk("rst_dp_cmd", {dp_clr, dp_step}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_job(0, 0);
    run_job(1, 0);
    run_job(2, 0);
    run_job(7, 0);
    run_job(8, 0);
    run_job(9, 0);
    run_job(31, 0);
    run_job(5, 10);
    run_job(3, 0);  // accepted right after the previous handshake
    for (int i = 0; i < 5; i++) begin
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    // Abort mid-EVAL: no response may follow.
    req_valid = 1'b1;
    req_n     = NW'(7);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_step", dp_step, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_dp_step", dp_step, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) stray++;
    end
    chk("abort_no_response", stray, 0);

    run_job(4, 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
